// File: rtl/minicpu_spi_fetch.sv
`default_nettype none
// ==========================================================================
// minicpu_spi_fetch : SPI-master opcode fetch with serial PCU operand load.
//   Optional macro MINICPU_SPI_FAST_READ_EN selects FAST_READ plus a dummy byte.
// Revision: 1.0
// ==========================================================================
module minicpu_spi_fetch #(
  parameter logic [7:0] pRdCmd  = 8'h03,
  parameter logic [7:0] pFstCmd = 8'h0B,
  parameter logic [3:0] pNFX    = 4'h2
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Req,
  input  logic [15:0] Addr,
  output logic        Busy,
  output logic        Ack,
  output logic [3:0]  IR,
  output logic [7:0]  DO,
  output logic        Op_En,
  output logic        Op_Inv,
  output logic        PCU_DI,
  output logic        CSn,
  output logic        SCK,
  output logic        MOSI,
  input  logic        MISO
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_CMD  = 3'd1;
  localparam logic [2:0] ST_ADR  = 3'd2;
  localparam logic [2:0] ST_DMY  = 3'd3;
  localparam logic [2:0] ST_DAT  = 3'd4;
  localparam logic [2:0] ST_END  = 3'd5;

  localparam logic [15:0] CMD_PAIR = {pFstCmd, pRdCmd};
`ifdef MINICPU_SPI_FAST_READ_EN
  localparam logic [7:0] CMD_BYTE = CMD_PAIR[15:8];
`else
  localparam logic [7:0] CMD_BYTE = CMD_PAIR[7:0];
`endif

  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic [4:0]  bitcnt;
  logic        phase;
  logic [15:0] addr_q;
  logic [7:0]  data_sr;
  logic        shifting;
  logic        bit_last;

  function automatic logic [4:0] reload(input logic [2:0] st);
    case (st)
      ST_ADR:                 reload = 5'd15;
      ST_CMD, ST_DMY, ST_DAT: reload = 5'd7;
      default:                reload = 5'd0;
    endcase
  endfunction

  assign shifting = (state == ST_CMD) || (state == ST_ADR) ||
                    (state == ST_DMY) || (state == ST_DAT);
  assign bit_last = phase && (bitcnt == 5'd0);

  // State register with the bit counter and SCK phase flag
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state  <= ST_IDLE;
      bitcnt <= 5'd0;
      phase  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        bitcnt <= reload(state_nxt);
        phase  <= 1'b0;
      end else if (shifting) begin
        phase <= ~phase;
        if (phase) bitcnt <= bitcnt - 5'd1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (Req) state_nxt = ST_CMD;
      ST_CMD:  if (bit_last) state_nxt = ST_ADR;
      ST_ADR: begin
        if (bit_last) begin
`ifdef MINICPU_SPI_FAST_READ_EN
          state_nxt = ST_DMY;
`else
          state_nxt = ST_DAT;
`endif
        end
      end
      ST_DMY:  if (bit_last) state_nxt = ST_DAT;
      ST_DAT:  if (bit_last) state_nxt = ST_END;
      ST_END:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    CSn    = 1'b1;
    SCK    = 1'b0;
    MOSI   = 1'b0;
    Busy   = (state != ST_IDLE);
    Ack    = 1'b0;
    Op_En  = 1'b0;
    Op_Inv = 1'b0;
    PCU_DI = 1'b0;
    case (state)
      ST_CMD: begin
        CSn  = 1'b0;
        SCK  = phase;
        MOSI = CMD_BYTE[bitcnt[2:0]];
      end
      ST_ADR: begin
        CSn  = 1'b0;
        SCK  = phase;
        MOSI = addr_q[bitcnt[3:0]];
      end
      ST_DMY: begin
        CSn = 1'b0;
        SCK = phase;
      end
      ST_DAT: begin
        CSn = 1'b0;
        SCK = phase;
        // Low nibble is forwarded one bit per SCK-high cycle as it arrives
        Op_En  = phase && (bitcnt <= 5'd3);
        Op_Inv = Op_En && (bitcnt == 5'd0) && (data_sr[7:4] == pNFX);
        PCU_DI = Op_En && data_sr[0];
      end
      ST_END:  Ack = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      addr_q  <= 16'h0000;
      data_sr <= 8'h00;
      DO      <= 8'h00;
      IR      <= 4'h0;
    end else begin
      if ((state == ST_IDLE) && Req) addr_q <= Addr;
      // MISO is taken on the edge that raises SCK
      if ((state == ST_DAT) && !phase) data_sr <= {data_sr[6:0], MISO};
      if ((state == ST_DAT) && (state_nxt == ST_END)) begin
        DO <= data_sr;
        IR <= data_sr[7:4];
      end
    end
  end

endmodule
`default_nettype wire
